// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared ST7789 command codes, panel geometry and sequencer state encoding
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
  localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int LCD_W        = 240;
  localparam int LCD_H        = 135;
  localparam int LCD_X_OFFSET = 40;
  localparam int LCD_Y_OFFSET = 53;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_CASET_CMD = 3'd1;
  localparam logic [2:0] ST_CASET_ARG = 3'd2;
  localparam logic [2:0] ST_RASET_CMD = 3'd3;
  localparam logic [2:0] ST_RASET_ARG = 3'd4;
  localparam logic [2:0] ST_RAMWR_CMD = 3'd5;
  localparam logic [2:0] ST_PIXEL     = 3'd6;
  localparam logic [2:0] ST_FIN       = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_CASET_CMD = ST_CASET_CMD,
    S_CASET_ARG = ST_CASET_ARG,
    S_RASET_CMD = ST_RASET_CMD,
    S_RASET_ARG = ST_RASET_ARG,
    S_RAMWR_CMD = ST_RAMWR_CMD,
    S_PIXEL     = ST_PIXEL,
    S_FIN       = ST_FIN
  } lcd_state_t;

  // Address-window argument order: start hi, start lo, end hi, end lo.
  function automatic logic [7:0] arg_byte(input logic [15:0] s, input logic [15:0] e,
                                          input logic [1:0] idx);
    unique case (idx)
      2'd0:    arg_byte = s[15:8];
      2'd1:    arg_byte = s[7:0];
      2'd2:    arg_byte = e[15:8];
      default: arg_byte = e[7:0];
    endcase
  endfunction

endpackage

// File: rtl/lcd_rect_fill_seq.sv
// rtl/lcd_rect_fill_seq.sv - streams CASET/RASET/RAMWR plus repeated fill colour into the SPI word FIFO
module lcd_rect_fill_seq
  import lcd_pkg::*;
#(
  parameter int X_OFFSET = LCD_X_OFFSET,
  parameter int Y_OFFSET = LCD_Y_OFFSET,
  parameter int COORD_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] y1,
  input  logic [15:0]        color,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               write_valid,
  input  logic               write_ready,
  output logic [8:0]         write_data
);

  localparam int NW = 2 * COORD_W + 1;

  lcd_state_t    state, state_next;
  logic [1:0]    arg_idx;
  logic [15:0]   xs, xe, ys, ye;
  logic [15:0]   color_q;
  logic [NW-1:0] pix_cnt;
  logic          phase;

  logic [NW-1:0] w_ext, h_ext, n_calc;
  logic          rect_ok, accept, fire;

  assign rect_ok = (x0 <= x1) && (y0 <= y1);
  assign accept  = (state == S_IDLE) && start && rect_ok;
  assign fire    = write_valid && write_ready;
  assign w_ext   = NW'(x1) - NW'(x0) + NW'(1);
  assign h_ext   = NW'(y1) - NW'(y0) + NW'(1);
  assign n_calc  = w_ext * h_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    write_valid = 1'b0;
    write_data  = 9'h000;
    busy        = (state != S_IDLE) && (state != S_FIN);
    done        = (state == S_FIN);
    unique case (state)
      S_IDLE: if (accept) state_next = S_CASET_CMD;
      S_CASET_CMD: begin
        write_valid = 1'b1;
        write_data  = {DC_CMD, LCD_CMD_CASET};
        if (fire) state_next = S_CASET_ARG;
      end
      S_CASET_ARG: begin
        write_valid = 1'b1;
        write_data  = {DC_DATA, arg_byte(xs, xe, arg_idx)};
        if (fire && arg_idx == 2'd3) state_next = S_RASET_CMD;
      end
      S_RASET_CMD: begin
        write_valid = 1'b1;
        write_data  = {DC_CMD, LCD_CMD_RASET};
        if (fire) state_next = S_RASET_ARG;
      end
      S_RASET_ARG: begin
        write_valid = 1'b1;
        write_data  = {DC_DATA, arg_byte(ys, ye, arg_idx)};
        if (fire && arg_idx == 2'd3) state_next = S_RAMWR_CMD;
      end
      S_RAMWR_CMD: begin
        write_valid = 1'b1;
        write_data  = {DC_CMD, LCD_CMD_RAMWR};
        if (fire) state_next = S_PIXEL;
      end
      S_PIXEL: begin
        write_valid = 1'b1;
        write_data  = {DC_DATA, phase ? color_q[7:0] : color_q[15:8]};
        if (fire && phase && pix_cnt == NW'(1)) state_next = S_FIN;
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Pixel counter decrements once per completed hi/lo pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      arg_idx <= 2'd0;
      xs      <= 16'h0000;
      xe      <= 16'h0000;
      ys      <= 16'h0000;
      ye      <= 16'h0000;
      color_q <= 16'h0000;
      pix_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      err <= (state == S_IDLE) && start && !rect_ok;
      if (accept) begin
        xs      <= 16'(X_OFFSET) + 16'(x0);
        xe      <= 16'(X_OFFSET) + 16'(x1);
        ys      <= 16'(Y_OFFSET) + 16'(y0);
        ye      <= 16'(Y_OFFSET) + 16'(y1);
        color_q <= color;
        pix_cnt <= n_calc;
        phase   <= 1'b0;
        arg_idx <= 2'd0;
      end
      if (fire && (state == S_CASET_ARG || state == S_RASET_ARG)) arg_idx <= arg_idx + 2'd1;
      if (fire && state == S_PIXEL) begin
        phase <= ~phase;
        if (phase) pix_cnt <= pix_cnt - NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lcd_rect_fill_seq.sv
// tb/tb_lcd_rect_fill_seq.sv - scoreboard bench for lcd_rect_fill_seq against a word-list reference model
module tb_lcd_rect_fill_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x0 = 8'd0, x1 = 8'd0, y0 = 8'd0, y1 = 8'd0;
  logic [15:0] color = 16'h0000;
  logic        busy, done, err, write_valid;
  logic        write_ready = 1'b1;
  logic [8:0]  write_data;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit ready_rand = 1'b0;
  logic [8:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_data = 9'h000;

  lcd_rect_fill_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .busy(busy), .done(done), .err(err),
    .write_valid(write_valid), .write_ready(write_ready), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the word list a panel would need for this rectangle.
  task automatic push_expected(input int ax0, input int ax1, input int ay0, input int ay1,
                               input int c);
    int xs, xe, ys, ye, n;
    xs = (ax0 + 40) % 65536;
    xe = (ax1 + 40) % 65536;
    ys = (ay0 + 53) % 65536;
    ye = (ay1 + 53) % 65536;
    n  = (ax1 - ax0 + 1) * (ay1 - ay0 + 1);
    exp_q.push_back(9'h02A);
    exp_q.push_back(9'(256 + xs / 256)); exp_q.push_back(9'(256 + xs % 256));
    exp_q.push_back(9'(256 + xe / 256)); exp_q.push_back(9'(256 + xe % 256));
    exp_q.push_back(9'h02B);
    exp_q.push_back(9'(256 + ys / 256)); exp_q.push_back(9'(256 + ys % 256));
    exp_q.push_back(9'(256 + ye / 256)); exp_q.push_back(9'(256 + ye % 256));
    exp_q.push_back(9'h02C);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(9'(256 + c / 256));
      exp_q.push_back(9'(256 + c % 256));
    end
  endtask

  always @(posedge clk) begin
    #1;
    write_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pop on every transfer, and hold the stalled word to its value.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", int'(write_valid), 1);
        chk("stall_data", int'(write_data), int'(prev_data));
      end
      if (write_valid && write_ready) begin
        if (exp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_word: got 0x%0h expected none", write_data);
        end else begin
          chk("word", int'(write_data), int'(exp_q.pop_front()));
        end
      end
    end
    prev_stall = rst_n && write_valid && !write_ready;
    prev_data  = write_data;
  end

  task automatic run_rect(input int ax0, input int ax1, input int ay0, input int ay1,
                          input int c, input bit midstart, input int exp_lat);
    int k, d0, e0;
    push_expected(ax0, ax1, ay0, ay1, c);
    d0 = done_cnt;
    e0 = err_cnt;
    @(posedge clk); #2;
    x0 = 8'(ax0); x1 = 8'(ax1); y0 = 8'(ay0); y1 = 8'(ay1); color = 16'(c);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    k = 0;
    while (!done && k < 70000) begin
      if (midstart && k == 3) begin
        start = 1'b1; x0 = 8'd1; x1 = 8'd3; y0 = 8'd2; y1 = 8'd2; color = 16'h1234;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #2;
      k++;
    end
    start = 1'b0;
    if (k >= 70000) begin
      checks++; fails++;
      $display("FAIL done_timeout: got no done expected done within 70000 cycles");
    end
    chk("busy_in_fin", int'(busy), 0);
    if (exp_lat > 0) chk("done_latency", k, exp_lat);
    @(posedge clk); #2;
    chk("done_one_cycle", int'(done), 0);
    chk("done_count", done_cnt, d0 + 1);
    chk("no_err", err_cnt, e0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int ax0, ax1, ay0, ay1, d0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(write_valid), 0);
    chk("rst_data", int'(write_data), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_rect(0, 0, 0, 0, 16'hF800, 1'b0, 13);
    run_rect(0, 239, 0, 134, 16'h07E0, 1'b0, 0);
    ready_rand = 1'b1;
    run_rect(3, 4, 7, 8, 16'hA55A, 1'b0, 0);

    ready_rand = 1'b0;
    d0 = err_cnt;
    @(posedge clk); #2;
    x0 = 8'd10; x1 = 8'd5; y0 = 8'd0; y1 = 8'd0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("err_pulse", int'(err), 1);
    chk("err_no_valid", int'(write_valid), 0);
    chk("err_no_busy", int'(busy), 0);
    @(posedge clk); #2;
    chk("err_one_cycle", int'(err), 0);
    chk("err_count", err_cnt, d0 + 1);
    run_rect(5, 10, 0, 0, 16'h001F, 1'b0, 0);

    push_expected(0, 7, 0, 7, 16'hBEEF);
    d0 = done_cnt;
    @(posedge clk); #2;
    x0 = 8'd0; x1 = 8'd7; y0 = 8'd0; y1 = 8'd7; color = 16'hBEEF; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", int'(write_valid), 0);
    chk("abort_busy", int'(busy), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_no_done", done_cnt, d0);
    run_rect(2, 2, 9, 9, 16'h0F0F, 1'b0, 13);

    ready_rand = 1'b1;
    run_rect(20, 23, 40, 41, 16'h5A5A, 1'b1, 0);
    for (int i = 0; i < 6; i++) begin
      ax0 = $urandom_range(0, 250);
      ax1 = ax0 + $urandom_range(0, 5);
      ay0 = $urandom_range(0, 250);
      ay1 = ay0 + $urandom_range(0, 4);
      ready_rand = 1'($urandom_range(0, 1));
      run_rect(ax0, ax1, ay0, ay1, int'($urandom_range(0, 65535)), 1'b0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
